// File: rtl/alu_result_demux_if.sv
// Handshake bundle between the ALU result port and the four result destinations.
// Optional flag outputs exist only when ALU_RESULT_FLAGS_EN is defined.
interface alu_result_demux_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        sel;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_data_0;
  logic [DATA_W-1:0] out_data_1;
  logic [DATA_W-1:0] out_data_2;
  logic [DATA_W-1:0] out_data_3;
  logic [CNT_W-1:0]  xfer_cnt_0;
  logic [CNT_W-1:0]  xfer_cnt_1;
  logic [CNT_W-1:0]  xfer_cnt_2;
  logic [CNT_W-1:0]  xfer_cnt_3;
`ifdef ALU_RESULT_FLAGS_EN
  logic [3:0]        out_zero;
  logic [3:0]        out_neg;

  modport master (
    output in_valid, sel, in_data, out_ready,
    input  in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3,
    input  xfer_cnt_0, xfer_cnt_1, xfer_cnt_2, xfer_cnt_3, out_zero, out_neg
  );
  modport slave (
    input  in_valid, sel, in_data, out_ready,
    output in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3,
    output xfer_cnt_0, xfer_cnt_1, xfer_cnt_2, xfer_cnt_3, out_zero, out_neg
  );
`else
  modport master (
    output in_valid, sel, in_data, out_ready,
    input  in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3,
    input  xfer_cnt_0, xfer_cnt_1, xfer_cnt_2, xfer_cnt_3
  );
  modport slave (
    input  in_valid, sel, in_data, out_ready,
    output in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3,
    output xfer_cnt_0, xfer_cnt_1, xfer_cnt_2, xfer_cnt_3
  );
`endif
endinterface

// File: rtl/alu_result_demux.sv
// Registered 1-to-4 ALU result demux with single-entry holding registers per destination.
// Define ALU_RESULT_FLAGS_EN to add per-destination zero/negative flags captured with the data.
module alu_result_demux #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  alu_result_demux_if.slave bus
);
  localparam int N_DEST = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } dest_state_e;

  dest_state_e       state_q [N_DEST];
  dest_state_e       state_d [N_DEST];
  logic [DATA_W-1:0] data_q  [N_DEST];
  logic [DATA_W-1:0] data_d  [N_DEST];
  logic [CNT_W-1:0]  cnt_q   [N_DEST];
  logic [CNT_W-1:0]  cnt_d   [N_DEST];

  logic [N_DEST-1:0] out_valid;
  logic [N_DEST-1:0] load;
  logic [DATA_W-1:0] store_val;
  logic              in_ready;

  always_comb begin
    for (int d = 0; d < N_DEST; d++) begin
      out_valid[d] = (state_q[d] == FULL);
    end
  end

  // A full destination can still accept when it is draining in the same cycle.
  assign in_ready  = ~out_valid[bus.sel] | bus.out_ready[bus.sel];
  assign store_val = (bus.sel == 2'd2) ? ~bus.in_data : bus.in_data;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    for (int d = 0; d < N_DEST; d++) begin
      load[d]    = bus.in_valid & in_ready & (bus.sel == 2'(d));
      state_d[d] = state_q[d];
      data_d[d]  = data_q[d];
      cnt_d[d]   = cnt_q[d];
      if (load[d]) begin
        state_d[d] = FULL;
        data_d[d]  = store_val;
        cnt_d[d]   = cnt_q[d] + 1'b1;
      end else if (state_q[d] == FULL && bus.out_ready[d]) begin
        state_d[d] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      // NOTE: holding registers are reset because their cleared contents are architecturally visible.
      for (int d = 0; d < N_DEST; d++) begin
        state_q[d] <= EMPTY;
        data_q[d]  <= '0;
        cnt_q[d]   <= '0;
      end
    end else begin
      for (int d = 0; d < N_DEST; d++) begin
        state_q[d] <= state_d[d];
        data_q[d]  <= data_d[d];
        cnt_q[d]   <= cnt_d[d];
      end
    end
  end

`ifdef ALU_RESULT_FLAGS_EN
  logic [N_DEST-1:0] zero_q, zero_d;
  logic [N_DEST-1:0] neg_q,  neg_d;

  // Flags describe the value actually stored, i.e. after the destination-2 inversion.
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    for (int d = 0; d < N_DEST; d++) begin
      if (load[d]) begin
        zero_d[d] = (store_val == '0);
        neg_d[d]  = store_val[DATA_W-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= '0;
      neg_q  <= '0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign bus.out_zero = zero_q;
  assign bus.out_neg  = neg_q;
`endif

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data_0 = data_q[0];
  assign bus.out_data_1 = data_q[1];
  assign bus.out_data_2 = data_q[2];
  assign bus.out_data_3 = data_q[3];
  assign bus.xfer_cnt_0 = cnt_q[0];
  assign bus.xfer_cnt_1 = cnt_q[1];
  assign bus.xfer_cnt_2 = cnt_q[2];
  assign bus.xfer_cnt_3 = cnt_q[3];
endmodule

// File: tb/tb_alu_result_demux.sv
// Directed self-checking bench for alu_result_demux; flag checks compile in with ALU_RESULT_FLAGS_EN.
module tb_alu_result_demux;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_result_demux_if #(.DATA_W(32), .CNT_W(8)) bus ();

  alu_result_demux #(.DATA_W(32), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.sel       = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++; if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid got %b want 0000", bus.out_valid); end
    n_checks++; if (bus.out_data_0 !== 32'h0) begin n_fail++; $display("FAIL reset_data_0 got %h want 0", bus.out_data_0); end
    n_checks++; if (bus.out_data_2 !== 32'h0) begin n_fail++; $display("FAIL reset_data_2 got %h want 0", bus.out_data_2); end
    n_checks++; if (bus.xfer_cnt_3 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt_3 got %0d want 0", bus.xfer_cnt_3); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic_accept();
    bus.in_valid = 1'b1; bus.sel = 2'd0; bus.in_data = 32'h0000_0005; bus.out_ready = 4'b0000;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_before got %b want 1", bus.in_ready); end
    step();
    n_checks++; if (bus.out_valid !== 4'b0001) begin n_fail++; $display("FAIL basic_out_valid got %b want 0001", bus.out_valid); end
    n_checks++; if (bus.out_data_0 !== 32'h5) begin n_fail++; $display("FAIL basic_data_0 got %h want 5", bus.out_data_0); end
    n_checks++; if (bus.xfer_cnt_0 !== 8'd1) begin n_fail++; $display("FAIL basic_cnt_0 got %0d want 1", bus.xfer_cnt_0); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_full got %b want 0", bus.in_ready); end
    idle();
    step();
    n_checks++; if (bus.xfer_cnt_0 !== 8'd1) begin n_fail++; $display("FAIL basic_cnt_hold got %0d want 1", bus.xfer_cnt_0); end
  endtask

  task automatic test_invert();
    bus.in_valid = 1'b1; bus.sel = 2'd2; bus.in_data = 32'hFFFF_FFF0;
    step();
    idle();
    n_checks++; if (bus.out_data_2 !== 32'h0000_000F) begin n_fail++; $display("FAIL invert_data_2 got %h want 0000000f", bus.out_data_2); end
    n_checks++; if (bus.out_valid !== 4'b0101) begin n_fail++; $display("FAIL invert_out_valid got %b want 0101", bus.out_valid); end
    n_checks++; if (bus.xfer_cnt_2 !== 8'd1) begin n_fail++; $display("FAIL invert_cnt_2 got %0d want 1", bus.xfer_cnt_2); end
`ifdef ALU_RESULT_FLAGS_EN
    n_checks++; if (bus.out_zero[2] !== 1'b0) begin n_fail++; $display("FAIL invert_zero_2 got %b want 0", bus.out_zero[2]); end
    n_checks++; if (bus.out_neg[2] !== 1'b0) begin n_fail++; $display("FAIL invert_neg_2 got %b want 0", bus.out_neg[2]); end
`endif
  endtask

  task automatic test_full_stall();
    bus.in_valid = 1'b1; bus.sel = 2'd1; bus.in_data = 32'h3;
    step();
    bus.in_data = 32'h7;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 0", i, bus.in_ready); end
      step();
      n_checks++; if (bus.out_data_1 !== 32'h3) begin n_fail++; $display("FAIL stall_data_1[%0d] got %h want 3", i, bus.out_data_1); end
      n_checks++; if (bus.xfer_cnt_1 !== 8'd1) begin n_fail++; $display("FAIL stall_cnt_1[%0d] got %0d want 1", i, bus.xfer_cnt_1); end
    end
    bus.out_ready = 4'b0010;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL refill_ready got %b want 1", bus.in_ready); end
    step();
    idle();
    n_checks++; if (bus.out_data_1 !== 32'h7) begin n_fail++; $display("FAIL refill_data_1 got %h want 7", bus.out_data_1); end
    n_checks++; if (bus.out_valid !== 4'b0111) begin n_fail++; $display("FAIL refill_out_valid got %b want 0111", bus.out_valid); end
    n_checks++; if (bus.xfer_cnt_1 !== 8'd2) begin n_fail++; $display("FAIL refill_cnt_1 got %0d want 2", bus.xfer_cnt_1); end
  endtask

  task automatic test_independent();
    bus.in_valid = 1'b1; bus.sel = 2'd3; bus.in_data = 32'h9;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL indep_ready got %b want 1", bus.in_ready); end
    step();
    idle();
    n_checks++; if (bus.out_data_3 !== 32'h9) begin n_fail++; $display("FAIL indep_data_3 got %h want 9", bus.out_data_3); end
    n_checks++; if (bus.out_data_0 !== 32'h5) begin n_fail++; $display("FAIL indep_data_0 got %h want 5", bus.out_data_0); end
    n_checks++; if (bus.out_valid !== 4'b1111) begin n_fail++; $display("FAIL indep_out_valid got %b want 1111", bus.out_valid); end
    n_checks++; if (bus.xfer_cnt_0 !== 8'd1) begin n_fail++; $display("FAIL indep_cnt_0 got %0d want 1", bus.xfer_cnt_0); end
  endtask

  task automatic test_drain();
    bus.out_ready = 4'b0001;
    step();
    n_checks++; if (bus.out_valid !== 4'b1110) begin n_fail++; $display("FAIL drain_out_valid got %b want 1110", bus.out_valid); end
    n_checks++; if (bus.out_data_0 !== 32'h5) begin n_fail++; $display("FAIL drain_data_0 got %h want 5", bus.out_data_0); end
    step();
    idle();
    n_checks++; if (bus.out_valid !== 4'b1110) begin n_fail++; $display("FAIL drain_empty_ready got %b want 1110", bus.out_valid); end
    n_checks++; if (bus.xfer_cnt_0 !== 8'd1) begin n_fail++; $display("FAIL drain_cnt_0 got %0d want 1", bus.xfer_cnt_0); end
  endtask

  task automatic test_back_to_back_wrap();
    bus.in_valid = 1'b1; bus.sel = 2'd3; bus.out_ready = 4'b1000;
    for (int i = 0; i < 254; i++) begin
      bus.in_data = 32'(i);
      step();
    end
    n_checks++; if (bus.xfer_cnt_3 !== 8'd255) begin n_fail++; $display("FAIL wrap_cnt_255 got %0d want 255", bus.xfer_cnt_3); end
    n_checks++; if (bus.out_data_3 !== 32'd253) begin n_fail++; $display("FAIL wrap_data_mid got %h want fd", bus.out_data_3); end
    bus.in_data = 32'h1234;
    step();
    idle();
    n_checks++; if (bus.xfer_cnt_3 !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt_0 got %0d want 0", bus.xfer_cnt_3); end
    n_checks++; if (bus.out_data_3 !== 32'h1234) begin n_fail++; $display("FAIL wrap_data_3 got %h want 1234", bus.out_data_3); end
    n_checks++; if (bus.out_valid !== 4'b1110) begin n_fail++; $display("FAIL wrap_out_valid got %b want 1110", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.sel = 2'd0; bus.in_data = 32'hAAAA_AAAA; bus.out_ready = 4'hF;
    step();
    reset = 1'b0;
    idle();
    n_checks++; if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_out_valid got %b want 0000", bus.out_valid); end
    n_checks++; if (bus.out_data_0 !== 32'h0) begin n_fail++; $display("FAIL rstmid_data_0 got %h want 0", bus.out_data_0); end
    n_checks++; if (bus.out_data_1 !== 32'h0) begin n_fail++; $display("FAIL rstmid_data_1 got %h want 0", bus.out_data_1); end
    n_checks++; if (bus.xfer_cnt_0 !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt_0 got %0d want 0", bus.xfer_cnt_0); end
    n_checks++; if (bus.xfer_cnt_1 !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt_1 got %0d want 0", bus.xfer_cnt_1); end
    n_checks++; if (bus.xfer_cnt_2 !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt_2 got %0d want 0", bus.xfer_cnt_2); end
  endtask

  task automatic test_flags();
    bus.in_valid = 1'b1; bus.sel = 2'd1; bus.in_data = 32'h0;
    step();
    bus.sel = 2'd0; bus.in_data = 32'h8000_0000;
    step();
    bus.sel = 2'd2; bus.in_data = 32'h0;
    step();
    idle();
    n_checks++; if (bus.out_valid !== 4'b0111) begin n_fail++; $display("FAIL flags_out_valid got %b want 0111", bus.out_valid); end
    n_checks++; if (bus.out_data_2 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flags_data_2 got %h want ffffffff", bus.out_data_2); end
    n_checks++; if (bus.xfer_cnt_1 !== 8'd1) begin n_fail++; $display("FAIL flags_cnt_1 got %0d want 1", bus.xfer_cnt_1); end
`ifdef ALU_RESULT_FLAGS_EN
    n_checks++; if (bus.out_zero !== 4'b0010) begin n_fail++; $display("FAIL flags_zero got %b want 0010", bus.out_zero); end
    n_checks++; if (bus.out_neg !== 4'b0101) begin n_fail++; $display("FAIL flags_neg got %b want 0101", bus.out_neg); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_basic_accept();
    test_invert();
    test_full_stall();
    test_independent();
    test_drain();
    test_back_to_back_wrap();
    test_reset_mid();
    test_flags();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
